adder_share_arbiter: RTL and testbench
======================================

# adder_share_arbiter

Round-robin arbiter and sequencer that shares one combinational `WIDTH`-bit adder (ports `a`, `b`, `Cin`, `S`, `Cout`, `Overflow`) among `NREQ` requesters. It sits between the requesting units and the shared adder instance. Each cycle it grants at most one requester, drives the adder operands, and captures the sum, carry and overflow into a one-entry response register with valid/ready backpressure. Every response is tagged with the requester id.

## Interface
- `WIDTH`, 32, operand/sum width
- `NREQ`, 4, number of requesters (2..16)
- `IDW`, $clog2(NREQ), id width
---
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `req_valid`  in  NREQ  per-requester request
- `req_ready`  out  NREQ  per-requester accept, one-hot or zero
- `req_a`  in  NREQ*WIDTH  operand A; requester i at slice [i*WIDTH +: WIDTH]
- `req_b`  in  NREQ*WIDTH  operand B; same slicing as `req_a`
- `req_cin`  in  NREQ  carry-in per requester
- `add_a`, `add_b`  out  WIDTH  operands to the shared adder
- `add_cin`  out  1  carry-in to the shared adder
- `add_s`  in  WIDTH  adder sum
- `add_cout`  in  1  adder carry-out
- `add_ovf`  in  1  adder signed overflow
- `rsp_valid`  out  1  response held
- `rsp_ready`  in  1  consumer accepts the response
- `rsp_id`  out  IDW  granted requester index
- `rsp_s`  out  WIDTH  registered sum
- `rsp_cout`, `rsp_ovf`  out  1  registered carry and overflow
- `issue_cnt`  out  32  total accepted requests, wraps modulo 2^32

## Operation
- The `can_issue` condition is `!rsp_valid || rsp_ready`.
- Grant selection:
  - Scan starts at the requester with index `rr_ptr` and wraps through `NREQ-1` to 0.
  - The first asserted `req_valid` bit wins.
  - The grant is combinational.
- `req_ready[g] = can_issue` for the granted index `g`. All other `req_ready` bits are 0. All bits are 0 when no request is pending or `rst_n` is low.
- Adder operands:
  - `add_a/add_b/add_cin` carry the granted requester's operands.
  - When there is no grant they are all zero.
- Accept means `req_valid[g] && req_ready[g]`. At the rising edge on accept:
  - `rsp_s <= add_s`, `rsp_cout <= add_cout`, `rsp_ovf <= add_ovf`, `rsp_id <= g`, `rsp_valid <= 1`.
  - `rr_ptr <= (g+1) mod NREQ`.
  - `issue_cnt` increments.
- No accept and `rsp_valid && rsp_ready`: `rsp_valid <= 0`, data fields hold their value.
- No accept and no drain: all registers hold.
- Simultaneous drain and accept: the new response replaces the old one with no bubble, and `rsp_valid` stays 1.
- `rr_ptr` changes only on accept. Requesters that are skipped keep their priority order.
- Protocol: a requester holds its operands stable while `req_valid` is high and it is not accepted. The arbiter never drops an accepted request.
- Adder semantics the bench models:
  - `S = (A+B+Cin) mod 2^WIDTH`.
  - `Cout` is the carry out of the MSB.
  - `Overflow = (A[W-1]==B[W-1]) && (S[W-1]!=A[W-1])`.

## Timing
- Reset values (asynchronous, while `rst_n` is low):
  - `rsp_valid=0`, `rsp_id=0`, `rsp_s=0`, `rsp_cout=0`, `rsp_ovf=0`, `issue_cnt=0`, `rr_ptr=0`.
  - `req_ready=0`; `add_a/add_b/add_cin=0`.
- Latency: a request accepted at edge N has `rsp_valid` high after edge N.
- Throughput: 1 accept per cycle while `rsp_ready` stays high.
- Backpressure: while `rsp_valid=1` and `rsp_ready=0`, every `req_ready` is 0 and `rsp_*` holds stable.
- Reset asserted mid-operation: any held response and any in-flight grant are discarded. After reset release the first grant goes to the lowest-index valid requester.
- `issue_cnt` wraps from 0xFFFFFFFF to 0.

## Test plan
- **Overflow case.** Requester 0 sends A=0x7FFFFFFF, B=1, Cin=0. Required response, one cycle after accept: `rsp_s`=0x80000000, `rsp_cout`=0, `rsp_ovf`=1, `rsp_id`=0.
- **Round-robin burst.** All four requesters are valid from reset with `rsp_ready`=1. Each sends A=i, B=10, Cin=1.
  - Grants go to 0,1,2,3 on consecutive cycles.
  - Responses are `rsp_s` = 11,12,13,14 with `rsp_cout`=0.
  - `issue_cnt`=4.
- **Rotation after a skip.** Only requester 2 is valid, with A=-10, B=-8. It is accepted, and the response is `rsp_s`=0xFFFFFFEE (-18), `cout`=1, `ovf`=0. Next, requesters 1 and 3 are both valid: requester 3 is granted first, then requester 1.
- **Backpressure.** `rsp_ready`=0 while requester 1 is valid with A=5, B=-3.
  - The first accept gives `rsp_s`=2, `cout`=1.
  - After that, `req_ready`=0 and the response holds for 5 cycles.
  - `rsp_ready` then pulses once, and the next request is accepted in that same cycle with no bubble.
- **Reset mid-operation.** Drop `rst_n` while `rsp_valid`=1 (holding MIN_INT + (-1), i.e. 0x7FFFFFFF, `cout`=1, `ovf`=1). All outputs clear immediately. After release, requester 0 with A=B=0, Cin=1 gives `rsp_s`=1.
- **Counter wrap.** Force or preload `issue_cnt` to 0xFFFFFFFF. One accept brings it to 0.

Source files
------------

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter that time-shares one external combinational adder among
// NREQ requesters and holds each result in a one-entry tagged response register.
module adder_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
  output logic [WIDTH-1:0]      add_a,
  output logic [WIDTH-1:0]      add_b,
  output logic                  add_cin,
  input  logic [WIDTH-1:0]      add_s,
  input  logic                  add_cout,
  input  logic                  add_ovf,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_s,
  output logic                  rsp_cout,
  output logic                  rsp_ovf,
  output logic [31:0]           issue_cnt
);

  localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

  logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]    rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]  rsp_s_q, rsp_s_d;
  logic              rsp_cout_q, rsp_cout_d;
  logic              rsp_ovf_q, rsp_ovf_d;
  logic [31:0]       issue_cnt_q, issue_cnt_d;

  logic [2*NREQ-1:0] dbl_valid;
  logic [NREQ-1:0]   rot_valid;
  logic              grant_found;
  logic [IDW:0]      grant_off;
  logic [IDW:0]      grant_sum;
  logic [IDW-1:0]    grant_idx;
  logic [IDW:0]      next_ptr;
  logic              can_issue;
  logic              accept;

  // Rotate the request vector so bit 0 is the requester at rr_ptr; the first
  // set bit then gives the offset of the winner from the pointer.
  always_comb begin
    dbl_valid   = {req_valid, req_valid} >> rr_ptr_q;
    rot_valid   = dbl_valid[NREQ-1:0];
    grant_found = 1'b0;
    grant_off   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!grant_found && rot_valid[k]) begin
        grant_found = 1'b1;
        grant_off   = (IDW+1)'(k);
      end
    end
    if (!rst_n) grant_found = 1'b0;
    grant_sum = {1'b0, rr_ptr_q} + grant_off;
    if (grant_sum >= NREQ_W) grant_sum = grant_sum - NREQ_W;
    grant_idx = grant_sum[IDW-1:0];
  end

  always_comb begin
    can_issue = !rsp_valid_q || rsp_ready;
    accept    = grant_found && can_issue;
    req_ready = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (grant_found) begin
      add_a   = req_a[grant_idx*WIDTH +: WIDTH];
      add_b   = req_b[grant_idx*WIDTH +: WIDTH];
      add_cin = req_cin[grant_idx];
    end
  end

  always_comb begin
    next_ptr    = {1'b0, grant_idx} + 1'b1;
    if (next_ptr >= NREQ_W) next_ptr = '0;
    rr_ptr_d    = rr_ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_s_d     = rsp_s_q;
    rsp_cout_d  = rsp_cout_q;
    rsp_ovf_d   = rsp_ovf_q;
    issue_cnt_d = issue_cnt_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = grant_idx;
      rsp_s_d     = add_s;
      rsp_cout_d  = add_cout;
      rsp_ovf_d   = add_ovf;
      rr_ptr_d    = next_ptr[IDW-1:0];
      issue_cnt_d = issue_cnt_q + 32'd1;
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_s_q     <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_ovf_q   <= 1'b0;
      issue_cnt_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_s_q     <= rsp_s_d;
      rsp_cout_q  <= rsp_cout_d;
      rsp_ovf_q   <= rsp_ovf_d;
      issue_cnt_q <= issue_cnt_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_s     = rsp_s_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign issue_cnt = issue_cnt_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter; includes a behavioural model of the
// shared adder driven from the arbiter's operand outputs.
module tb_adder_share_arbiter;
  localparam int W = 32;
  localparam int N = 4;
  localparam int I = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N*W-1:0] req_a, req_b;
  logic [N-1:0]  req_cin;
  logic [W-1:0]  add_a, add_b, add_s;
  logic          add_cin, add_cout, add_ovf;
  logic          rsp_valid, rsp_ready;
  logic [I-1:0]  rsp_id;
  logic [W-1:0]  rsp_s;
  logic          rsp_cout, rsp_ovf;
  logic [31:0]   issue_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  adder_share_arbiter #(.WIDTH(W), .NREQ(N), .IDW(I)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout), .add_ovf(add_ovf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_s(rsp_s), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf),
    .issue_cnt(issue_cnt)
  );

  // Shared adder model
  always_comb begin
    {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};
    add_ovf = (add_a[W-1] == add_b[W-1]) && (add_s[W-1] != add_a[W-1]);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_cin[i]      = c;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_cin = '0; rsp_ready = 1'b1;
    set_req(1, 32'h1234, 32'h1, 1'b1);
    req_valid = 4'b0010;
    #12;
    total++; if (rsp_valid !== 1'b0)  begin bad++; $display("FAIL reset_rsp_valid got=%0b exp=0", rsp_valid); end
    total++; if (req_ready !== 4'b0)  begin bad++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
    total++; if (add_a !== 32'h0 || add_b !== 32'h0 || add_cin !== 1'b0)
      begin bad++; $display("FAIL reset_operands got a=%h b=%h c=%0b exp=0", add_a, add_b, add_cin); end
    total++; if (issue_cnt !== 32'h0 || rsp_s !== 32'h0 || rsp_id !== 2'd0)
      begin bad++; $display("FAIL reset_regs got cnt=%h s=%h id=%0d exp=0", issue_cnt, rsp_s, rsp_id); end
    req_valid = '0;
  endtask

  task automatic test_overflow();
    @(negedge clk);
    rst_n = 1'b1; rsp_ready = 1'b1;
    set_req(0, 32'h7FFF_FFFF, 32'h1, 1'b0);
    req_valid = 4'b0001;
    #1;
    total++; if (req_ready !== 4'b0001 || add_a !== 32'h7FFF_FFFF)
      begin bad++; $display("FAIL ovf_grant got ready=%b a=%h exp=0001/7fffffff", req_ready, add_a); end
    @(negedge clk);
    req_valid = '0;
    total++; if (rsp_valid !== 1'b1 || rsp_s !== 32'h8000_0000 || rsp_cout !== 1'b0 || rsp_ovf !== 1'b1 || rsp_id !== 2'd0)
      begin bad++; $display("FAIL ovf_rsp got v=%0b s=%h c=%0b o=%0b id=%0d exp=1/80000000/0/1/0",
                            rsp_valid, rsp_s, rsp_cout, rsp_ovf, rsp_id); end
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int i = 0; i < N; i++) set_req(i, W'(i), 32'd10, 1'b1);
    req_valid = 4'b1111; rsp_ready = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      #1;
      total++; if (req_ready !== 4'(1 << i))
        begin bad++; $display("FAIL rr_grant%0d got=%b exp=%b", i, req_ready, 4'(1 << i)); end
      @(negedge clk);
      if (i == N-1) req_valid = '0;
      total++; if (rsp_valid !== 1'b1 || rsp_id !== I'(i) || rsp_s !== 32'(11 + i) || rsp_cout !== 1'b0)
        begin bad++; $display("FAIL rr_rsp%0d got v=%0b id=%0d s=%0d c=%0b exp=1/%0d/%0d/0",
                              i, rsp_valid, rsp_id, rsp_s, rsp_cout, i, 11 + i); end
    end
    total++; if (issue_cnt !== 32'd4) begin bad++; $display("FAIL rr_count got=%0d exp=4", issue_cnt); end
  endtask

  task automatic test_skip_rotation();
    set_req(2, 32'hFFFF_FFF6, 32'hFFFF_FFF8, 1'b0);
    req_valid = 4'b0100;
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL skip_grant2 got=%b exp=0100", req_ready); end
    @(negedge clk);
    total++; if (rsp_s !== 32'hFFFF_FFEE || rsp_cout !== 1'b1 || rsp_ovf !== 1'b0 || rsp_id !== 2'd2)
      begin bad++; $display("FAIL skip_rsp got s=%h c=%0b o=%0b id=%0d exp=ffffffee/1/0/2", rsp_s, rsp_cout, rsp_ovf, rsp_id); end
    set_req(1, 32'd100, 32'd1, 1'b0);
    set_req(3, 32'd300, 32'd3, 1'b0);
    req_valid = 4'b1010;
    #1;
    total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL skip_grant3 got=%b exp=1000", req_ready); end
    @(negedge clk);
    req_valid = 4'b0010;
    total++; if (rsp_id !== 2'd3 || rsp_s !== 32'd303) begin bad++; $display("FAIL skip_rsp3 got id=%0d s=%0d exp=3/303", rsp_id, rsp_s); end
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL skip_grant1 got=%b exp=0010", req_ready); end
    @(negedge clk);
    req_valid = '0;
    total++; if (rsp_id !== 2'd1 || rsp_s !== 32'd101) begin bad++; $display("FAIL skip_rsp1 got id=%0d s=%0d exp=1/101", rsp_id, rsp_s); end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%0b exp=0", rsp_valid); end
    rsp_ready = 1'b0;
    set_req(1, 32'd5, 32'hFFFF_FFFD, 1'b0);
    req_valid = 4'b0010;
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL bp_first_grant got=%b exp=0010", req_ready); end
    @(negedge clk);
    total++; if (rsp_valid !== 1'b1 || rsp_s !== 32'd2 || rsp_cout !== 1'b1 || rsp_ovf !== 1'b0)
      begin bad++; $display("FAIL bp_first_rsp got v=%0b s=%h c=%0b o=%0b exp=1/2/1/0", rsp_valid, rsp_s, rsp_cout, rsp_ovf); end
    set_req(1, 32'd7, 32'd8, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++; if (req_ready !== 4'b0 || rsp_valid !== 1'b1 || rsp_s !== 32'd2 || rsp_id !== 2'd1)
        begin bad++; $display("FAIL bp_hold%0d got ready=%b v=%0b s=%h id=%0d exp=0000/1/2/1", k, req_ready, rsp_valid, rsp_s, rsp_id); end
    end
    rsp_ready = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL bp_pulse_grant got=%b exp=0010", req_ready); end
    @(negedge clk);
    rsp_ready = 1'b0; req_valid = '0;
    total++; if (rsp_valid !== 1'b1 || rsp_s !== 32'd15 || rsp_id !== 2'd1)
      begin bad++; $display("FAIL bp_nobubble got v=%0b s=%0d id=%0d exp=1/15/1", rsp_valid, rsp_s, rsp_id); end
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    total++; if (rsp_valid !== 1'b1 || rsp_s !== 32'd15) begin bad++; $display("FAIL mid_hold_prev got v=%0b s=%0d exp=1/15", rsp_valid, rsp_s); end
    rsp_ready = 1'b1;
    set_req(0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    req_valid = 4'b0001;
    @(negedge clk);
    rsp_ready = 1'b0;
    set_req(0, 32'd0, 32'd0, 1'b1);
    set_req(3, 32'd9, 32'd9, 1'b0);
    req_valid = 4'b1001;
    total++; if (rsp_valid !== 1'b1 || rsp_s !== 32'h7FFF_FFFF || rsp_cout !== 1'b1 || rsp_ovf !== 1'b1)
      begin bad++; $display("FAIL mid_rsp got v=%0b s=%h c=%0b o=%0b exp=1/7fffffff/1/1", rsp_valid, rsp_s, rsp_cout, rsp_ovf); end
    #2;
    rsp_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    total++; if (rsp_valid !== 1'b0 || rsp_s !== 32'h0 || rsp_cout !== 1'b0 || rsp_ovf !== 1'b0 || issue_cnt !== 32'h0)
      begin bad++; $display("FAIL mid_clear got v=%0b s=%h c=%0b o=%0b cnt=%h exp=all 0", rsp_valid, rsp_s, rsp_cout, rsp_ovf, issue_cnt); end
    total++; if (req_ready !== 4'b0 || add_a !== 32'h0 || add_cin !== 1'b0)
      begin bad++; $display("FAIL mid_grant_clear got ready=%b a=%h c=%0b exp=0", req_ready, add_a, add_cin); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL mid_first_grant got=%b exp=0001", req_ready); end
    @(negedge clk);
    req_valid = '0;
    total++; if (rsp_valid !== 1'b1 || rsp_s !== 32'd1 || rsp_id !== 2'd0)
      begin bad++; $display("FAIL mid_after_rsp got v=%0b s=%0d id=%0d exp=1/1/0", rsp_valid, rsp_s, rsp_id); end
  endtask

  task automatic test_count_wrap();
    @(negedge clk);
    force dut.issue_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.issue_cnt_q;
    #1;
    total++; if (issue_cnt !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap_preload got=%h exp=ffffffff", issue_cnt); end
    set_req(2, 32'd1, 32'd2, 1'b0);
    req_valid = 4'b0100;
    @(negedge clk);
    req_valid = '0;
    total++; if (issue_cnt !== 32'h0 || rsp_s !== 32'd3)
      begin bad++; $display("FAIL wrap_count got cnt=%h s=%0d exp=0/3", issue_cnt, rsp_s); end
  endtask

  initial begin
    test_reset();
    test_overflow();
    test_round_robin();
    test_skip_rotation();
    test_backpressure();
    test_reset_midop();
    test_count_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
